// File: rtl/apb_regfile_gen.sv
// apb_regfile_gen: parameterised APB register file with per-register access
// types (RW, RO, WO, W1S, W1C, RC), a configurable number of wait states and
// hardware hooks (hw_in for RO registers, hw_set for W1C/RC registers).
// Optional feature: define REGFILE_IRQ_EN to add a registered irq output that
// is the OR of every bit of every W1C register.
module apb_regfile_gen #(
  parameter int unsigned                      ADDR_WIDTH   = 8,
  parameter int unsigned                      DATA_WIDTH   = 32,
  parameter int unsigned                      NUM_REGS     = 8,
  parameter int unsigned                      WAIT_STATES  = 0,
  parameter logic [3*NUM_REGS-1:0]            ACCESS_TYPES = '0,
  parameter logic [DATA_WIDTH*NUM_REGS-1:0]   RESET_VALUES = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
`ifdef REGFILE_IRQ_EN
  ,
  output logic                           irq
`endif
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  typedef enum logic [2:0] {
    ACC_RW  = 3'd0,
    ACC_RO  = 3'd1,
    ACC_WO  = 3'd2,
    ACC_W1S = 3'd3,
    ACC_W1C = 3'd4,
    ACC_RC  = 3'd5
  } acc_t;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_nx;
  logic                   w_ready_nx;
  logic                   r_pready;
  logic                   r_pslverr;
  logic [DATA_WIDTH-1:0]  r_prdata;

  logic [DATA_WIDTH-1:0]  r_regs    [NUM_REGS];
  logic [DATA_WIDTH-1:0]  w_regs_nx [NUM_REGS];

  logic [ADDR_WIDTH-3:0]  w_idx;
  logic                   w_dec_err;
  logic [NUM_REGS-1:0]    w_hit;
  acc_t                   w_sel_type;
  logic [DATA_WIDTH-1:0]  w_sel_val;
  logic [DATA_WIDTH-1:0]  w_rd_data;
  logic                   w_err;
  logic [DATA_WIDTH-1:0]  w_lane_mask;
  logic                   w_done;
  logic                   w_wr;
  logic                   w_rd;

  // Address decode: word index plus misalignment / out-of-range error.
  always_comb begin
    w_idx     = paddr[ADDR_WIDTH-1:2];
    w_dec_err = (paddr[1:0] != 2'b00) || (32'(w_idx) >= NUM_REGS);
  end

  // Select the addressed register's type and value.
  always_comb begin
    w_hit      = '0;
    w_sel_type = ACC_RW;
    w_sel_val  = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!w_dec_err && (32'(w_idx) == i)) begin
        w_hit[i]   = 1'b1;
        w_sel_type = acc_t'(ACCESS_TYPES[3*i +: 3]);
        w_sel_val  = r_regs[i];
      end
    end
    w_rd_data = (w_dec_err || (w_sel_type == ACC_WO)) ? '0 : w_sel_val;
    w_err     = w_dec_err || (pwrite && (w_sel_type == ACC_RO));
  end

  // Expand byte strobes into a bit mask.
  always_comb begin
    w_lane_mask = '0;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      w_lane_mask[8*b +: 8] = {8{pstrb[b]}};
    end
  end

  // Bus FSM next state and wait counter; pready is registered, so it is
  // computed from the next state/counter to assert exactly while cnt==0.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (psel && !penable) w_state_nx = S_SETUP;
      end
      S_SETUP: begin
        if (!psel) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_ACCESS;
          w_cnt_nx   = 4'(WAIT_STATES);
        end
      end
      S_ACCESS: begin
        if (!psel || r_pready) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
    w_ready_nx = (w_state_nx == S_ACCESS) && (w_cnt_nx == 4'd0);
  end

  // Completing-cycle qualifiers; side effects happen only here.
  always_comb begin
    w_done = psel && penable && r_pready;
    w_wr   = w_done && pwrite;
    w_rd   = w_done && !pwrite;
  end

  // FSM state, wait counter and registered bus responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_pready  <= w_ready_nx;
      r_pslverr <= w_ready_nx && w_err;
      r_prdata  <= (w_ready_nx && !pwrite) ? w_rd_data : '0;
    end
  end

  // Per-register next value by access type. RC clears only the bits that
  // were actually returned on prdata, so a hw_set landing between the data
  // capture and the completing edge is not lost.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      w_regs_nx[i] = r_regs[i];
      case (acc_t'(ACCESS_TYPES[3*i +: 3]))
        ACC_RO: begin
          w_regs_nx[i] = hw_in[DATA_WIDTH*i +: DATA_WIDTH];
        end
        ACC_RW, ACC_WO: begin
          if (w_wr && w_hit[i])
            w_regs_nx[i] = (r_regs[i] & ~w_lane_mask) | (pwdata & w_lane_mask);
        end
        ACC_W1S: begin
          if (w_wr && w_hit[i])
            w_regs_nx[i] = r_regs[i] | (pwdata & w_lane_mask);
        end
        ACC_W1C: begin
          if (w_wr && w_hit[i])
            w_regs_nx[i] = r_regs[i] & ~(pwdata & w_lane_mask);
          w_regs_nx[i] = w_regs_nx[i] | hw_set[DATA_WIDTH*i +: DATA_WIDTH];
        end
        ACC_RC: begin
          if (w_rd && w_hit[i])
            w_regs_nx[i] = r_regs[i] & ~r_prdata;
          w_regs_nx[i] = w_regs_nx[i] | hw_set[DATA_WIDTH*i +: DATA_WIDTH];
        end
        default: begin
          w_regs_nx[i] = r_regs[i];
        end
      endcase
    end
  end

  // Register storage with per-register reset values.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rst) r_regs[i] <= RESET_VALUES[DATA_WIDTH*i +: DATA_WIDTH];
      else     r_regs[i] <= w_regs_nx[i];
    end
  end

  // Flatten register contents onto reg_out.
  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_out[DATA_WIDTH*i +: DATA_WIDTH] = r_regs[i];
    end
  end

  assign prdata  = r_prdata;
  assign pready  = r_pready;
  assign pslverr = r_pslverr;

`ifdef REGFILE_IRQ_EN
  logic w_w1c_any;
  logic r_irq;

  // OR of every W1C register bit.
  always_comb begin
    w_w1c_any = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (acc_t'(ACCESS_TYPES[3*i +: 3]) == ACC_W1C)
        w_w1c_any = w_w1c_any | (|r_regs[i]);
    end
  end

  // Registered interrupt, one cycle behind the W1C contents.
  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= w_w1c_any;
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_apb_regfile_gen.sv
// tb_apb_regfile_gen: directed self-checking bench for apb_regfile_gen.
// Register map: 0 RW, 1 RO, 2 WO, 3 W1C, 4 RC, 5 W1S, 6 RW, 7 RW; 2 wait states.
module tb_apb_regfile_gen;

  localparam logic [23:0]  TYPES = {3'd0, 3'd0, 3'd3, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};
  localparam logic [255:0] RVALS = {32'h7777_7777, 32'h6666_6666, 32'h0000_0010,
                                    32'h0000_0003, 32'h0000_00FF, 32'hCAFE_F00D,
                                    32'h0000_BEEF, 32'h1234_5678};

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   paddr;
  logic         psel, penable, pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata;
  logic         pready, pslverr;
  logic [255:0] hw_in, hw_set, reg_out;
`ifdef REGFILE_IRQ_EN
  logic         irq;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_rd [8] = '{32'h1234_5678, 32'h0000_BEEF, 32'h0000_0000, 32'h0000_00FF,
                              32'h0000_0003, 32'h0000_0010, 32'h6666_6666, 32'h7777_7777};

  apb_regfile_gen #(
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (32),
    .NUM_REGS    (8),
    .WAIT_STATES (2),
    .ACCESS_TYPES(TYPES),
    .RESET_VALUES(RVALS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .paddr  (paddr),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .pwdata (pwdata),
    .pstrb  (pstrb),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr),
    .hw_in  (hw_in),
    .hw_set (hw_set),
    .reg_out(reg_out)
`ifdef REGFILE_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One APB transfer; set_at_done is driven on hw_set during the pready cycle.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [255:0] set_at_done,
                      output logic [31:0] rdata, output logic err, output int waits);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    do begin
      @(posedge clk); #1;
      waits++;
    end while (!pready && waits < 20);
    if (!pready) check("pready_timeout", {63'd0, pready}, 64'd1);
    rdata  = prdata;
    err    = pslverr;
    hw_set = set_at_done;
    @(posedge clk); #1;
    hw_set = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          wt;
  logic        seen_ready;

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; hw_set = '0;
    hw_in = '0;
    hw_in[63:32] = 32'h0000_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready",  {63'd0, pready},  64'd0);
    check("rst_pslverr", {63'd0, pslverr}, 64'd0);
    check("rst_prdata",  {32'd0, prdata},  64'd0);
    for (int i = 0; i < 8; i++)
      check("rst_reg", {32'd0, reg_out[32*i +: 32]}, {32'd0, RVALS[32*i +: 32]});
    rst = 1'b0;

    // Read every register after reset (RC reg4 clears as a side effect).
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, 8'(4*i), '0, 4'h0, '0, rd, er, wt);
      check("sweep_rd",  {32'd0, rd}, {32'd0, exp_rd[i]});
      check("sweep_err", {63'd0, er}, 64'd0);
    end
    check("prdata_idle", {32'd0, prdata}, 64'd0);
    check("rc_cleared_by_sweep", {32'd0, reg_out[159:128]}, 64'd0);

    // Partial-strobe write with wait states.
    xfer(1'b1, 8'h00, 32'hA5A5_0000, 4'b1100, '0, rd, er, wt);
    check("ws_access_cycles", 64'(wt), 64'd3);
    check("ws_err", {63'd0, er}, 64'd0);
    check("rw_lanes_reg0", {32'd0, reg_out[31:0]}, 64'hA5A5_5678);

    // W1C clear with concurrent hw_set of bit 0.
    xfer(1'b1, 8'h0C, 32'h0000_000F, 4'hF, 256'h1 << 96, rd, er, wt);
    check("w1c_reg3", {32'd0, reg_out[127:96]}, 64'hF1);
`ifdef REGFILE_IRQ_EN
    check("irq_set", {63'd0, irq}, 64'd1);
`endif
    xfer(1'b1, 8'h0C, 32'h0000_00F1, 4'hF, '0, rd, er, wt);
    check("w1c_reg3_clear", {32'd0, reg_out[127:96]}, 64'h0);
`ifdef REGFILE_IRQ_EN
    check("irq_lag", {63'd0, irq}, 64'd1);
    @(posedge clk); #1;
    check("irq_clear", {63'd0, irq}, 64'd0);
`endif

    // RC: load 0x3 via hw_set, read it back, expect clear afterwards.
    hw_set[159:128] = 32'h3;
    @(posedge clk); #1;
    hw_set = '0;
    check("rc_loaded", {32'd0, reg_out[159:128]}, 64'h3);
    xfer(1'b0, 8'h10, '0, 4'h0, '0, rd, er, wt);
    check("rc_rd", {32'd0, rd}, 64'h3);
    check("rc_after", {32'd0, reg_out[159:128]}, 64'h0);

    // W1S, WO and RW lane tests.
    xfer(1'b1, 8'h14, 32'h0000_0101, 4'b0001, '0, rd, er, wt);
    check("w1s_reg5", {32'd0, reg_out[191:160]}, 64'h11);
    xfer(1'b1, 8'h08, 32'h1122_3344, 4'hF, '0, rd, er, wt);
    check("wo_reg2", {32'd0, reg_out[95:64]}, 64'h1122_3344);
    xfer(1'b0, 8'h08, '0, 4'h0, '0, rd, er, wt);
    check("wo_rd_zero", {32'd0, rd}, 64'h0);
    xfer(1'b1, 8'h18, 32'hAABB_CCDD, 4'b0101, '0, rd, er, wt);
    check("rw_lanes_reg6", {32'd0, reg_out[223:192]}, 64'h66BB_66DD);

    // Error cases.
    xfer(1'b0, 8'h02, '0, 4'h0, '0, rd, er, wt);
    check("misalign_err", {63'd0, er}, 64'd1);
    check("misalign_rd",  {32'd0, rd}, 64'h0);
    xfer(1'b0, 8'h20, '0, 4'h0, '0, rd, er, wt);
    check("range_err", {63'd0, er}, 64'd1);
    xfer(1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF, '0, rd, er, wt);
    check("range_wr_err", {63'd0, er}, 64'd1);
    check("range_wr_reg0", {32'd0, reg_out[31:0]}, 64'hA5A5_5678);
    xfer(1'b1, 8'h04, 32'h1234_5678, 4'hF, '0, rd, er, wt);
    check("ro_wr_err", {63'd0, er}, 64'd1);
    check("ro_wr_reg1", {32'd0, reg_out[63:32]}, 64'hBEEF);
    hw_in[63:32] = 32'h0000_5555;
    @(posedge clk); #1;
    check("ro_tracks", {32'd0, reg_out[63:32]}, 64'h5555);

    // Reset asserted during ACCESS aborts the write.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("mid_access_no_ready", {63'd0, pready}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen_ready = seen_ready | pready;
      @(posedge clk); #1;
    end
    check("abort_no_pready", {63'd0, seen_ready}, 64'd0);
    check("abort_reg0", {32'd0, reg_out[31:0]},    64'h1234_5678);
    check("abort_reg3", {32'd0, reg_out[127:96]},  64'hFF);
    check("abort_reg4", {32'd0, reg_out[159:128]}, 64'h3);
    check("abort_reg6", {32'd0, reg_out[223:192]}, 64'h6666_6666);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_regfile_gen.md
APB_REGFILE_GEN -- requirements
Module: apb_regfile_gen

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: width of the APB byte address.
REQ-002 Parameter DATA_WIDTH, default 32: register and bus width, a multiple of 8.
REQ-003 Parameter NUM_REGS, default 8: number of registers; register i sits at byte address 4*i.
REQ-004 Parameter WAIT_STATES, default 0: extra ACCESS cycles before pready, range 0..15.
REQ-005 Parameter ACCESS_TYPES, default all 0: 3 bits per register giving its type: 0 RW, 1 RO, 2 WO, 3 W1S, 4 W1C, 5 RC (read-clear).
REQ-006 Parameter RESET_VALUES, default all 0: DATA_WIDTH bits per register giving its reset value.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 paddr  in  ADDR_WIDTH  APB address.
REQ-010 psel, penable, pwrite  in  1 each  APB control.
REQ-011 pwdata  in  DATA_WIDTH  write data.
REQ-012 pstrb  in  DATA_WIDTH/8  byte write strobes.
REQ-013 prdata  out  DATA_WIDTH  registered read data.
REQ-014 pready, pslverr  out  1 each  transfer complete and error.
REQ-015 hw_in  in  NUM_REGS*DATA_WIDTH  hardware value for each RO register.
REQ-016 hw_set  in  NUM_REGS*DATA_WIDTH  hardware bit-set events for W1C and RC registers.
REQ-017 reg_out  out  NUM_REGS*DATA_WIDTH  current value of every register, flattened.

Function
REQ-018 The bus FSM SHALL use three states: IDLE, SETUP and ACCESS.
- IDLE->SETUP when psel=1 and penable=0.
- SETUP->ACCESS unconditionally.
- ACCESS->IDLE on the cycle pready=1.
REQ-019 A wait counter SHALL load WAIT_STATES on entry to ACCESS and decrement each cycle; pready SHALL be 1 for exactly one cycle, when the counter is 0 in ACCESS, and 0 otherwise.
REQ-020 Side effects SHALL occur only on the completing cycle (psel & penable & pready): register updates, RC clears and error flags.
REQ-021 An access is a decode error when paddr[1:0]!=0 or paddr>>2 >= NUM_REGS.
REQ-022 pslverr SHALL be 1 with pready for:
- a decode error;
- a write to an RO register.
In both cases no register changes.
REQ-023 Writes SHALL apply per byte lane enabled by pstrb:
- RW and WO load the lane;
- W1S ORs pwdata into the lane;
- W1C clears bits where pwdata=1;
- RC writes are ignored, with no error.
REQ-024 Reads SHALL return the register value for RW, RO, W1S, W1C and RC registers, and 0 for WO registers and decode errors.
- prdata is registered and valid while pready=1.
- prdata is 0 at all other times.
REQ-025 An RC register SHALL clear to 0 in the cycle after its read completes.
REQ-026 RO registers SHALL load hw_in every cycle.
REQ-027 W1C and RC registers SHALL OR in hw_set every cycle; hw_set wins over a simultaneous bus clear of the same bit.
REQ-028 If psel drops mid-transfer, the FSM SHALL return to IDLE, with no side effects and no pready.

Reset
REQ-029 While rst=1 at a clock edge:
- FSM SHALL go to IDLE and the wait counter to 0;
- prdata, pready and pslverr SHALL be 0;
- every register SHALL take its RESET_VALUES slice;
- irq, when present, SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no register side effect.

Configuration
REQ-031 With macro REGFILE_IRQ_EN defined:
- output port irq (1 bit) SHALL exist;
- irq is registered and equals the OR of all bits of all W1C registers, with one cycle latency.
REQ-032 Without REGFILE_IRQ_EN, the irq port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-033 Reset, then read every address -> prdata equals each RESET_VALUES slice, pslverr=0, with WO registers reading 0.
REQ-034 WAIT_STATES=2, write 0xA5A5_0000 with pstrb=4'b1100 to RW reg0 (reset 0x1234_5678) -> pready on the 3rd ACCESS cycle, reg_out[0]=0xA5A5_5678.
REQ-035 Write 0x0F to W1C reg3 holding 0xFF, with hw_set bit 0 pulsed in the same cycle -> reg3=0xF1.
- With REGFILE_IRQ_EN, irq=1 until reg3 is cleared by writing 0xF1, then irq=0 one cycle later.
REQ-036 Read RC reg4 holding 0x3 -> prdata=0x3, reg4=0 on the next cycle.
REQ-037 Cover the error cases:
- paddr=0x02 -> pslverr=1;
- paddr=4*NUM_REGS -> pslverr=1;
- write to RO reg1 -> pslverr=1 and reg1 still tracks hw_in;
- rst=1 during ACCESS -> no pready and registers at reset values.
